// File: rtl/pmem_loader_pkg.sv
// Shared constants for the program-memory loader: FSM state encoding and data widths.
package pmem_loader_pkg;

    localparam int INSTR_W        = 12;
    localparam int BYTE_W         = 8;
    localparam int NWORDS_DEFAULT = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LO    = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

endpackage

// File: rtl/pmem_loader.sv
// Packs a byte stream into 12-bit instructions and writes them to program memory via le/la/li.
// Optional trailing XOR checksum byte when PMEM_LOADER_CHECKSUM_EN is defined.
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEFAULT,
    parameter int AW     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               le,
    output logic [AW-1:0]      la,
    output logic [INSTR_W-1:0] li,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AW-1:0]      count
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    logic [2:0]         state_q, state_d;
    logic [AW-1:0]      count_q, count_d;
    logic [AW-1:0]      la_q, la_d;
    logic [INSTR_W-1:0] li_q, li_d;
    logic               hs;

    assign hs = in_valid && in_ready;

`ifdef PMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_LAST = S_CSUM;
    logic [BYTE_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) && start) begin
            csum_d = '0;
        end else if ((state_q == S_LO || state_q == S_HI) && hs) begin
            csum_d = csum_q ^ in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`else
    localparam logic [2:0] S_AFTER_LAST = S_DONE;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        la_d    = la_q;
        li_d    = li_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LO;
                    count_d = '0;
                    la_d    = '0;
                end
            end
`ifdef PMEM_LOADER_CHECKSUM_EN
            S_ERR: begin
                if (start) begin
                    state_d = S_LO;
                    count_d = '0;
                    la_d    = '0;
                end
            end
            S_CSUM: begin
                if (hs) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_LO: begin
                if (hs) begin
                    li_d[7:0] = in_data;
                    state_d   = S_HI;
                end
            end
            S_HI: begin
                // Upper nibble of the high byte is dropped from the word.
                if (hs) begin
                    li_d[11:8] = in_data[3:0];
                    la_d       = count_q;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_q + AW'(1);
                state_d = (count_q == LAST_ADDR) ? S_AFTER_LAST : S_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            la_q    <= '0;
            li_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            la_q    <= la_d;
            li_q    <= li_d;
        end
    end

    // All handshake/status outputs decode the state register only.
    always_comb begin
        in_ready = (state_q == S_LO) || (state_q == S_HI);
        busy     = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_WRITE);
`ifdef PMEM_LOADER_CHECKSUM_EN
        in_ready = in_ready || (state_q == S_CSUM);
        busy     = busy || (state_q == S_CSUM);
        err      = (state_q == S_ERR);
`else
        err      = 1'b0;
`endif
    end

    assign le    = (state_q == S_WRITE);
    assign done  = (state_q == S_DONE);
    assign la    = la_q;
    assign li    = li_q;
    assign count = count_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Self-checking bench for pmem_loader: directed sequence with random data/gaps against a queue-based model.
module tb_pmem_loader;
    import pmem_loader_pkg::*;

    localparam int NW = 10;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, le, busy, done, err;
    logic [AW-1:0] la, count;
    logic [11:0]   li;

    int tests = 0;
    int fails = 0;

    logic [7:0]    img[$];
    logic [AW-1:0] la_log[$];
    logic [11:0]   li_log[$];
    int            viol = 0;
    logic          prev_le = 1'b0;

    pmem_loader #(.NWORDS(NW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .le(le), .la(la), .li(li), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    // Capture every write pulse; le must be isolated and never coincide with in_ready.
    always @(negedge clk) begin
        if (le) begin
            la_log.push_back(la);
            li_log.push_back(li);
            if (prev_le || in_ready) viol++;
        end
        prev_le = le;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xor_bytes(input int n);
        logic [7:0] x = '0;
        for (int i = 0; i < n; i++) x ^= img[i];
        return x;
    endfunction

    task automatic build_image(input bit sequential);
        img.delete();
        for (int i = 0; i < 2 * NW; i++) img.push_back(sequential ? 8'(i) : 8'($urandom));
    endtask

    task automatic add_csum(input bit corrupt);
`ifdef PMEM_LOADER_CHECKSUM_EN
        img.push_back(xor_bytes(2 * NW) ^ {7'd0, corrupt});
`else
        if (corrupt) img.push_back(8'hFF);
`endif
    endtask

    task automatic clear_logs();
        la_log.delete();
        li_log.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feeds img[0..nbytes-1]; gap_pct = chance of idle in_valid per cycle; start pulsed at cycle glitch_at.
    task automatic stream(input int gap_pct, input int glitch_at, input int nbytes,
                          input bit drain, output int busy_cyc, output bit timed_out);
        int idx = 0;
        int cyc = 0;
        busy_cyc  = 0;
        timed_out = 1'b0;
        while (idx < nbytes && cyc < 3000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? img[idx] : 8'($urandom);
            start    = (cyc == glitch_at);
            @(negedge clk);
            if (busy) busy_cyc++;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (drain) begin
            while (cyc < 3000) begin
                @(negedge clk);
                if (!busy) break;
                busy_cyc++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (cyc >= 3000) timed_out = 1'b1;
    endtask

    task automatic check_image(input string tag);
        check({tag, "_nle"}, la_log.size(), NW);
        for (int k = 0; k < NW && k < la_log.size(); k++) begin
            check($sformatf("%s_la%0d", tag, k), la_log[k], k);
            check($sformatf("%s_li%0d", tag, k), li_log[k], {img[2*k+1][3:0], img[2*k]});
        end
    endtask

    initial begin
        int  bc;
        bit  to;
        int  exp_cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_le", le, 0);
        check("rst_la", la, 0);
        check("rst_li", li, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        rst = 1'b0;

        // Sequential image, in_valid always high: exact cycle count.
        build_image(1'b1);
        add_csum(1'b0);
        clear_logs();
        pulse_start();
        stream(0, -1, img.size(), 1'b1, bc, to);
        check("t1_timeout", to, 0);
`ifdef PMEM_LOADER_CHECKSUM_EN
        exp_cyc = 3 * NW + 1;
`else
        exp_cyc = 3 * NW;
`endif
        check("t1_busy_cycles", bc, exp_cyc);
        check_image("t1");
        check("t1_word1", li_log.size() > 1 ? li_log[1] : 12'h0, 12'h302);
        check("t1_done", done, 1);
        check("t1_err", err, 0);
        check("t1_count", count, NW);
        check("t1_la_hold", la, NW - 1);
        check("t1_li_hold", li, {img[2*NW-1][3:0], img[2*NW-2]});

        // Restart from DONE clears status, then random data with gaps and a start while busy.
        build_image(1'b0);
        img[4] = 8'h55;
        img[5] = 8'hFA;
        add_csum(1'b0);
        clear_logs();
        pulse_start();
        @(negedge clk);
        check("t2_done_clr", done, 0);
        check("t2_count_clr", count, 0);
        check("t2_busy", busy, 1);
        @(posedge clk); #1;
        stream(50, 7, img.size(), 1'b1, bc, to);
        check("t2_timeout", to, 0);
        check_image("t2");
        check("t2_mask", li_log.size() > 2 ? li_log[2] : 12'h0, 12'hA55);
        check("t2_done", done, 1);
        check("t2_count", count, NW);

`ifdef PMEM_LOADER_CHECKSUM_EN
        // Corrupted checksum: memory still written, err instead of done.
        build_image(1'b0);
        add_csum(1'b1);
        clear_logs();
        pulse_start();
        stream(20, -1, img.size(), 1'b1, bc, to);
        check("t3_timeout", to, 0);
        check_image("t3");
        check("t3_err", err, 1);
        check("t3_done", done, 0);
        check("t3_busy", busy, 0);
`endif

        // Reset while waiting for the high byte of word 3; reset beats a simultaneous start.
        build_image(1'b0);
        add_csum(1'b0);
        clear_logs();
        pulse_start();
        stream(30, -1, 7, 1'b0, bc, to);
        check("t4_timeout", to, 0);
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = img[7];
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("t4_in_ready", in_ready, 0);
        check("t4_le", le, 0);
        check("t4_la", la, 0);
        check("t4_li", li, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_err", err, 0);
        check("t4_count", count, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_nle", la_log.size(), 3);
        check("t4_idle", busy, 0);
        in_valid = 1'b0;

        // Fresh load after reset starts again at address 0.
        clear_logs();
        pulse_start();
        stream(30, -1, img.size(), 1'b1, bc, to);
        check("t5_timeout", to, 0);
        check_image("t5");
        check("t5_done", done, 1);
        check("t5_count", count, NW);

        check("le_protocol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
